// File: rtl/pkt_pkg.sv
// Shared packet format used by the PE, this port adapter and the crossbar.
// Layout MSB..LSB is {v, c, y, x, p}; the field macros expect D_W/X_W/Y_W/C_W in scope.
`ifndef PKT_PKG_SV
`define PKT_PKG_SV

`define Packet  logic [1+C_W+Y_W+X_W+D_W-1:0]
`define Payload logic [D_W-1:0]
`define PktP(pkt)  pkt[D_W-1:0]
`define PktX(pkt)  pkt[D_W +: X_W]
`define PktY(pkt)  pkt[D_W+X_W +: Y_W]
`define PktC(pkt)  pkt[D_W+X_W+Y_W +: C_W]
`define PktV(pkt)  pkt[D_W+X_W+Y_W+C_W]

package pkt_pkg;

    function automatic int pktWidth(input int dW, input int xW, input int yW, input int cW);
        return 1 + cW + yW + xW + dW;
    endfunction

endpackage

`endif

// File: rtl/xbar_pe_port_fifo.sv
// Synchronous FIFO with occupancy counter; full is judged before a same-cycle pop,
// so a push into a full FIFO is refused even if the head leaves that cycle.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic             doPush, doPop;

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign head   = mem_q[rdPtr_q];
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the empty flag masks stale entries.
    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= din;
    end

endmodule

// File: rtl/xbar_pe_port.sv
// Network-side adapter for one PE: captures held packets with a one-cycle ack, queues them
// toward the crossbar, and filters/strips crossbar deliveries for this (X,Y,C) address.
module xbar_pe_port
    import pkt_pkg::*;
#(
    parameter int D_W   = 32,
    parameter int X_W   = 2,
    parameter int Y_W   = 2,
    parameter int C_W   = 2,
    parameter int DEPTH = 4,
    parameter int X     = 0,
    parameter int Y     = 0,
    parameter int C     = 0,
    localparam int PKT_W = pktWidth(D_W, X_W, Y_W, C_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PKT_W-1:0] pe_packet,
    output logic             ack,
    output logic [PKT_W-1:0] xb_out_packet,
    output logic             xb_out_vld,
    input  logic             xb_out_rdy,
    input  logic             xb_in_vld,
    input  logic [PKT_W-1:0] xb_in_packet,
    output logic             pein_vld,
    output logic [D_W-1:0]   pein_payload,
    output logic [15:0]      misroute_cnt,
    output logic             fifo_full
);
    logic                   ack_q, ack_d;
    logic                   fifoPush, fifoPop, fifoEmpty;
    logic [PKT_W-1:0]       fifoHead;
    logic [$clog2(DEPTH):0] unusedCount;
    logic                   unusedInValid;

    logic                   peinVld_q, peinVld_d;
    `Payload                peinPayload_q, peinPayload_d;
    logic [15:0]            misrouteCnt_q, misrouteCnt_d;
    logic                   destHit;

    // The PE keeps driving the old packet during the ack cycle, so ack_q blocks a double capture.
    assign fifoPush = `PktV(pe_packet) && !fifo_full && !ack_q;
    assign ack_d    = fifoPush;
    assign fifoPop  = xb_out_vld && xb_out_rdy;

    sync_fifo #(
        .W     (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifoPush),
        .pop   (fifoPop),
        .din   (pe_packet),
        .head  (fifoHead),
        .full  (fifo_full),
        .empty (fifoEmpty),
        .count (unusedCount)
    );

    assign xb_out_vld = !fifoEmpty;

    always_comb begin
        xb_out_packet = '0;
        if (!fifoEmpty) begin
            xb_out_packet = fifoHead;
            `PktV(xb_out_packet) = 1'b1;
        end
    end

    // Deliveries are qualified only by xb_in_vld; the packet's own valid bit is not consulted.
    assign unusedInValid = `PktV(xb_in_packet);
    assign destHit = (`PktX(xb_in_packet) == X_W'(X)) &&
                     (`PktY(xb_in_packet) == Y_W'(Y)) &&
                     (`PktC(xb_in_packet) == C_W'(C));

    always_comb begin
        peinVld_d     = 1'b0;
        peinPayload_d = peinPayload_q;
        misrouteCnt_d = misrouteCnt_q;
        if (xb_in_vld) begin
            if (destHit) begin
                peinVld_d     = 1'b1;
                peinPayload_d = `PktP(xb_in_packet);
            end else if (misrouteCnt_q != 16'hFFFF) begin
                misrouteCnt_d = misrouteCnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_q         <= 1'b0;
            peinVld_q     <= 1'b0;
            peinPayload_q <= '0;
            misrouteCnt_q <= '0;
        end else begin
            ack_q         <= ack_d;
            peinVld_q     <= peinVld_d;
            peinPayload_q <= peinPayload_d;
            misrouteCnt_q <= misrouteCnt_d;
        end
    end

    assign ack          = ack_q;
    assign pein_vld     = peinVld_q;
    assign pein_payload = peinPayload_q;
    assign misroute_cnt = misrouteCnt_q;

endmodule

// File: tb/tb_xbar_pe_port.sv
// Self-checking bench for xbar_pe_port: directed scenarios plus a queue-based scoreboard
// and a delivery model for randomized traffic.
module tb_xbar_pe_port;
    localparam int D_W   = 32;
    localparam int X_W   = 2;
    localparam int Y_W   = 2;
    localparam int C_W   = 2;
    localparam int DEPTH = 4;
    localparam int MY_X  = 1;
    localparam int MY_Y  = 2;
    localparam int MY_C  = 3;
    localparam int NPKT  = 1000;

    typedef struct packed {
        logic        v;
        logic [1:0]  c;
        logic [1:0]  y;
        logic [1:0]  x;
        logic [31:0] p;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst;
    pkt_t        pe_packet;
    logic        ack;
    pkt_t        xb_out_packet;
    logic        xb_out_vld;
    logic        xb_out_rdy;
    logic        xb_in_vld;
    pkt_t        xb_in_packet;
    logic        pein_vld;
    logic [31:0] pein_payload;
    logic [15:0] misroute_cnt;
    logic        fifo_full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xbar_pe_port #(
        .D_W(D_W), .X_W(X_W), .Y_W(Y_W), .C_W(C_W), .DEPTH(DEPTH),
        .X(MY_X), .Y(MY_Y), .C(MY_C)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pe_packet     (pe_packet),
        .ack           (ack),
        .xb_out_packet (xb_out_packet),
        .xb_out_vld    (xb_out_vld),
        .xb_out_rdy    (xb_out_rdy),
        .xb_in_vld     (xb_in_vld),
        .xb_in_packet  (xb_in_packet),
        .pein_vld      (pein_vld),
        .pein_payload  (pein_payload),
        .misroute_cnt  (misroute_cnt),
        .fifo_full     (fifo_full)
    );

    function automatic pkt_t mkPkt(input logic [1:0] c, input logic [1:0] y,
                                   input logic [1:0] x, input logic [31:0] p);
        pkt_t r;
        r.v = 1'b1; r.c = c; r.y = y; r.x = x; r.p = p;
        return r;
    endfunction

    function automatic pkt_t randPkt(input logic [31:0] p);
        return mkPkt(2'($urandom), 2'($urandom), 2'($urandom), p);
    endfunction

    task automatic test_reset();
        rst = 1'b0; pe_packet = '0; xb_out_rdy = 1'b0; xb_in_vld = 1'b0; xb_in_packet = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack got %b want 0", ack); end
        checks++; if (xb_out_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_xb_out_vld got %b want 0", xb_out_vld); end
        checks++; if (pein_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_pein_vld got %b want 0", pein_vld); end
        checks++; if (misroute_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_misroute got %0d want 0", misroute_cnt); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_fifo_full got %b want 0", fifo_full); end
        checks++; if (xb_out_packet !== '0) begin errors++; $display("[TB] FAIL reset_xb_out_packet got %h want 0", xb_out_packet); end
        checks++; if (pein_payload !== 32'd0) begin errors++; $display("[TB] FAIL reset_pein_payload got %h want 0", pein_payload); end
        rst = 1'b1;
    endtask

    task automatic test_single();
        pkt_t pkt;
        pkt = mkPkt(2'd2, 2'd1, 2'd3, 32'h0001_0005);
        @(negedge clk);
        pe_packet = pkt; xb_out_rdy = 1'b1;
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL single_ack got %b want 1", ack); end
        checks++; if (xb_out_vld !== 1'b1) begin errors++; $display("[TB] FAIL single_vld got %b want 1", xb_out_vld); end
        checks++; if (xb_out_packet !== pkt) begin errors++; $display("[TB] FAIL single_packet got %h want %h", xb_out_packet, pkt); end
        pe_packet = '0;
        @(negedge clk);
        checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL single_ack_pulse got %b want 0", ack); end
        checks++; if (xb_out_vld !== 1'b0) begin errors++; $display("[TB] FAIL single_empty got %b want 0", xb_out_vld); end
    endtask

    task automatic test_full();
        pkt_t fp[5];
        int   ackCount = 0;
        logic prevAck  = 1'b0;
        for (int i = 0; i < 5; i++) fp[i] = randPkt(32'hF000_0000 + 32'(i));
        xb_out_rdy = 1'b0;
        pe_packet  = fp[0];
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            checks++; if (ack === 1'b1 && prevAck === 1'b1) begin errors++; $display("[TB] FAIL full_ack_spacing got back-to-back acks at cycle %0d want gap", cyc); end
            prevAck = ack;
            if (ack === 1'b1) begin
                ackCount++;
                if (ackCount < 5) pe_packet = fp[ackCount];
            end
        end
        checks++; if (ackCount != DEPTH) begin errors++; $display("[TB] FAIL full_ack_count got %0d want %0d", ackCount, DEPTH); end
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("[TB] FAIL full_flag got %b want 1", fifo_full); end
        ackCount   = 0;
        xb_out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (xb_out_packet !== fp[i] || xb_out_vld !== 1'b1) begin errors++; $display("[TB] FAIL full_drain_%0d got %h vld %b want %h", i, xb_out_packet, xb_out_vld, fp[i]); end
            @(negedge clk);
            if (ack === 1'b1) begin ackCount++; pe_packet = '0; end
        end
        checks++; if (ackCount != 1) begin errors++; $display("[TB] FAIL full_fifth_ack got %0d want 1", ackCount); end
        checks++; if (xb_out_vld !== 1'b0) begin errors++; $display("[TB] FAIL full_drained got %b want 0", xb_out_vld); end
        xb_out_rdy = 1'b0;
    endtask

    task automatic test_back_to_back();
        pkt_t sb[$];
        pkt_t peCur, expHead, junk;
        logic expAck = 1'b0;
        logic peHold = 1'b0;
        logic rdy, cap;
        int   sent = 0, cycles = 0;
        peCur = '0;
        while ((sent < NPKT || peHold || expAck || sb.size() != 0) && cycles < 20000) begin
            checks++; if (ack !== expAck) begin errors++; $display("[TB] FAIL b2b_ack cycle %0d got %b want %b", cycles, ack, expAck); end
            checks++; if (xb_out_vld !== (sb.size() != 0)) begin errors++; $display("[TB] FAIL b2b_vld cycle %0d got %b want %b", cycles, xb_out_vld, sb.size() != 0); end
            checks++; if (fifo_full !== (sb.size() == DEPTH)) begin errors++; $display("[TB] FAIL b2b_full cycle %0d got %b want %b", cycles, fifo_full, sb.size() == DEPTH); end
            if (sb.size() != 0) begin
                expHead = sb[0];
                checks++; if (xb_out_packet !== expHead) begin errors++; $display("[TB] FAIL b2b_head cycle %0d got %h want %h", cycles, xb_out_packet, expHead); end
            end
            if (expAck) peHold = 1'b0;
            if (!peHold && sent < NPKT && $urandom_range(3) != 0) begin
                peCur  = randPkt({16'(sent), 16'($urandom)});
                peHold = 1'b1;
                sent++;
            end
            junk       = randPkt($urandom);
            junk.v     = 1'b0;
            pe_packet  = peHold ? peCur : junk;
            rdy        = 1'($urandom_range(1));
            xb_out_rdy = rdy;
            cap = peHold && (sb.size() < DEPTH) && !expAck;
            if (sb.size() != 0 && rdy) void'(sb.pop_front());
            if (cap) sb.push_back(peCur);
            expAck = cap;
            cycles++;
            @(negedge clk);
        end
        checks++; if (cycles >= 20000) begin errors++; $display("[TB] FAIL b2b_timeout got %0d cycles want < 20000", cycles); end
        pe_packet  = '0;
        xb_out_rdy = 1'b0;
    endtask

    task automatic test_receive();
        pkt_t        pkt;
        logic        expVld = 1'b0;
        logic [31:0] expPayload = 32'd0;
        int          expCnt = 0;
        logic        vld, hit;
        pkt = mkPkt(2'(MY_C), 2'(MY_Y), 2'(MY_X), 32'hDEAD_BEEF);
        xb_in_vld = 1'b1; xb_in_packet = pkt;
        @(negedge clk);
        xb_in_vld = 1'b0;
        checks++; if (pein_vld !== 1'b1) begin errors++; $display("[TB] FAIL rx_hit_vld got %b want 1", pein_vld); end
        checks++; if (pein_payload !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL rx_hit_payload got %h want deadbeef", pein_payload); end
        pkt.c = pkt.c ^ 2'd1; pkt.p = 32'h1234_5678;
        xb_in_vld = 1'b1; xb_in_packet = pkt;
        @(negedge clk);
        xb_in_vld = 1'b0;
        checks++; if (pein_vld !== 1'b0) begin errors++; $display("[TB] FAIL rx_miss_vld got %b want 0", pein_vld); end
        checks++; if (misroute_cnt !== 16'd1) begin errors++; $display("[TB] FAIL rx_miss_cnt got %0d want 1", misroute_cnt); end
        checks++; if (pein_payload !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL rx_miss_hold got %h want deadbeef", pein_payload); end
        expPayload = 32'hDEAD_BEEF; expCnt = 1;
        for (int i = 0; i < 300; i++) begin
            vld = 1'($urandom_range(1));
            pkt = ($urandom_range(1) != 0) ? mkPkt(2'(MY_C), 2'(MY_Y), 2'(MY_X), $urandom) : randPkt($urandom);
            xb_in_vld = vld; xb_in_packet = pkt;
            hit = (int'(pkt.x) == MY_X) && (int'(pkt.y) == MY_Y) && (int'(pkt.c) == MY_C);
            expVld = vld && hit;
            if (vld && hit) expPayload = pkt.p;
            if (vld && !hit && expCnt < 65535) expCnt++;
            @(negedge clk);
            checks++; if (pein_vld !== expVld) begin errors++; $display("[TB] FAIL rx_rand_vld %0d got %b want %b", i, pein_vld, expVld); end
            checks++; if (pein_payload !== expPayload) begin errors++; $display("[TB] FAIL rx_rand_payload %0d got %h want %h", i, pein_payload, expPayload); end
            checks++; if (misroute_cnt !== 16'(expCnt)) begin errors++; $display("[TB] FAIL rx_rand_cnt %0d got %0d want %0d", i, misroute_cnt, expCnt); end
        end
        xb_in_vld = 1'b0;
    endtask

    task automatic test_reset_midstream();
        pkt_t mp[4];
        int   n = 0;
        for (int i = 0; i < 4; i++) mp[i] = randPkt(32'hA500_0000 + 32'(i));
        xb_out_rdy = 1'b0;
        pe_packet  = mp[0];
        for (int cyc = 0; cyc < 10 && n < 3; cyc++) begin
            @(negedge clk);
            if (ack === 1'b1) begin n++; pe_packet = mp[n]; end
        end
        checks++; if (n != 3) begin errors++; $display("[TB] FAIL mid_fill got %0d acks want 3", n); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ack got %b want 0", ack); end
        checks++; if (xb_out_vld !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_vld got %b want 0", xb_out_vld); end
        checks++; if (misroute_cnt !== 16'd0) begin errors++; $display("[TB] FAIL mid_reset_cnt got %0d want 0", misroute_cnt); end
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL mid_reack got %b want 1", ack); end
        checks++; if (xb_out_packet !== mp[3]) begin errors++; $display("[TB] FAIL mid_head got %h want %h", xb_out_packet, mp[3]); end
        pe_packet  = '0;
        xb_out_rdy = 1'b1;
        @(negedge clk);
        checks++; if (xb_out_vld !== 1'b0) begin errors++; $display("[TB] FAIL mid_final_empty got %b want 0", xb_out_vld); end
        xb_out_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_receive();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
